// File: rtl/sdram_write_fifo_pkg.sv
// rtl/sdram_write_fifo_pkg.sv - entry layout and DQM packing for the SDRAM write FIFO
package sdram_write_fifo_pkg;

   localparam int SDRAM_DQM_WIDTH = 4;
   localparam int DATA_WIDTH      = 32;
   localparam int ENTRY_WIDTH     = SDRAM_DQM_WIDTH + DATA_WIDTH;
   localparam int DATA_LSB        = 0;
   localparam int DQM_LSB         = DATA_WIDTH;

   // DQM is active-high "do not write", the inverse of the host byte enables.
   function automatic logic [ENTRY_WIDTH-1:0] make_entry(
      input logic [DATA_WIDTH-1:0]      data,
      input logic [SDRAM_DQM_WIDTH-1:0] byte_en
   );
      return {~byte_en, data};
   endfunction

endpackage

// File: rtl/sdram_fifo_ram.sv
// rtl/sdram_fifo_ram.sv - simple dual-port entry RAM, synchronous write, registered read
import sdram_write_fifo_pkg::*;

module sdram_fifo_ram #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [ENTRY_WIDTH-1:0] wr_data,
   input  logic                   rd_en,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [ENTRY_WIDTH-1:0] rd_data
);

   logic [ENTRY_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   // Array is left uninitialised on reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sdram_write_fifo.sv
// rtl/sdram_write_fifo.sv - host-word FIFO feeding the SDRAM write sequencer
import sdram_write_fifo_pkg::*;

module sdram_write_fifo #(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_MARGIN  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic [SDRAM_DQM_WIDTH-1:0] wr_byte_en,
   output logic                       full,
   output logic                       almost_full,
   output logic [ADDR_WIDTH:0]        count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       fifo_read,
   output logic [ENTRY_WIDTH-1:0]     fifo_data,
   output logic                       fifo_empty
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_MARGIN);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   free_cnt;
   logic                  push_ok;
   logic                  pop_ok;

   assign fifo_empty  = (count == '0);
   assign full        = (count == DEPTH_C);
   assign free_cnt    = DEPTH_C - count;
   assign almost_full = (free_cnt <= AF_C);

   // Acceptance uses pre-edge flags only; no write-to-read bypass.
   assign push_ok = wr_en & ~full;
   assign pop_ok  = fifo_read & ~fifo_empty;

   sdram_fifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_ok & ~rst),
      .wr_addr (wr_ptr),
      .wr_data (make_entry(wr_data, wr_byte_en)),
      .rd_en   (pop_ok),
      .rd_addr (rd_ptr),
      .rd_data (fifo_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (wr_en & full) begin
            overflow <= 1'b1;
         end
         if (fifo_read & fifo_empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_write_fifo.sv
// tb/tb_sdram_write_fifo.sv - directed self-checking bench for sdram_write_fifo
module tb_sdram_write_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [3:0]  wr_byte_en;
   logic        full;
   logic        almost_full;
   logic [4:0]  count;
   logic        overflow;
   logic        underflow;
   logic        fifo_read;
   logic [35:0] fifo_data;
   logic        fifo_empty;

   int total = 0;
   int bad   = 0;

   sdram_write_fifo #(
      .ADDR_WIDTH (4),
      .AF_MARGIN  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .wr_byte_en  (wr_byte_en),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .fifo_read   (fifo_read),
      .fifo_data   (fifo_data),
      .fifo_empty  (fifo_empty)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] be);
      wr_en      = 1'b1;
      wr_data    = d;
      wr_byte_en = be;
      step();
      wr_en      = 1'b0;
   endtask

   task automatic pop();
      fifo_read = 1'b1;
      step();
      fifo_read = 1'b0;
   endtask

   initial begin
      logic [35:0] held;
      rst        = 1'b1;
      wr_en      = 1'b1;
      wr_data    = 32'hAAAA5555;
      wr_byte_en = 4'hF;
      fifo_read  = 1'b0;

      // reset held two cycles with a push request active
      step();
      step();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(fifo_empty), 64'd1);
      chk("rst_data", 64'(fifo_data), 64'h0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_udf", 64'(underflow), 64'd0);
      rst   = 1'b0;
      wr_en = 1'b0;
      step();
      chk("rst_nostore", 64'(fifo_empty), 64'd1);

      // single word with a masked byte
      push(32'hDEADBEEF, 4'b1101);
      chk("single_count1", 64'(count), 64'd1);
      chk("single_notempty", 64'(fifo_empty), 64'd0);
      pop();
      chk("single_data", 64'(fifo_data), 64'h2_DEADBEEF);
      chk("single_empty", 64'(fifo_empty), 64'd1);
      chk("single_count0", 64'(count), 64'd0);

      // fill to full, almost_full from count 14
      for (int i = 0; i < 16; i++) begin
         push(32'h1000_0000 + 32'(i), 4'(i));
         chk($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
         chk($sformatf("fill_af%0d", i), 64'(almost_full), 64'((i + 1) >= 14));
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_ovf_pre", 64'(overflow), 64'd0);
      push(32'hBAD0BAD0, 4'hF);
      chk("ovf_count", 64'(count), 64'd16);
      chk("ovf_flag", 64'(overflow), 64'd1);

      // held fifo_read drains in order
      fifo_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("drain_data%0d", i), 64'(fifo_data),
             64'({~4'(i), 32'h1000_0000 + 32'(i)}));
      end
      fifo_read = 1'b0;
      chk("drain_empty", 64'(fifo_empty), 64'd1);
      chk("drain_full", 64'(full), 64'd0);

      // push/pop pairs across pointer wrap
      for (int k = 0; k < 20; k++) begin
         push(32'h0000_0100 + 32'(k), 4'hF);
         pop();
         chk($sformatf("wrap_data%0d", k), 64'(fifo_data), 64'({4'h0, 32'h0000_0100 + 32'(k)}));
      end
      chk("wrap_empty", 64'(fifo_empty), 64'd1);

      // simultaneous push/pop at count 5
      for (int k = 0; k < 5; k++) push(32'h200 + 32'(k), 4'b0011);
      chk("sim_count5", 64'(count), 64'd5);
      wr_en      = 1'b1;
      fifo_read  = 1'b1;
      wr_byte_en = 4'b0011;
      for (int k = 0; k < 10; k++) begin
         wr_data = 32'h205 + 32'(k);
         step();
         chk($sformatf("sim_data%0d", k), 64'(fifo_data), 64'({4'b1100, 32'h200 + 32'(k)}));
         chk($sformatf("sim_count%0d", k), 64'(count), 64'd5);
      end
      wr_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("sim_tail%0d", k), 64'(fifo_data), 64'({4'b1100, 32'h20A + 32'(k)}));
      end
      fifo_read = 1'b0;
      chk("sim_empty", 64'(fifo_empty), 64'd1);
      chk("sim_udf_pre", 64'(underflow), 64'd0);

      // simultaneous push/pop at empty: pop ignored, push accepted
      wr_en      = 1'b1;
      fifo_read  = 1'b1;
      wr_data    = 32'h0000_0300;
      wr_byte_en = 4'b1000;
      step();
      wr_en     = 1'b0;
      fifo_read = 1'b0;
      chk("empty_both_udf", 64'(underflow), 64'd1);
      chk("empty_both_count", 64'(count), 64'd1);
      chk("empty_both_data", 64'(fifo_data), 64'({4'b1100, 32'h20E}));

      // hold behaviour
      pop();
      held = 36'h7_0000_0300;
      chk("hold_pop", 64'(fifo_data), 64'(held));
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("hold_stable%0d", k), 64'(fifo_data), 64'(held));
      end
      pop();
      chk("hold_empty_pop", 64'(fifo_data), 64'(held));
      chk("hold_count", 64'(count), 64'd0);

      // reset mid-operation at count 9
      for (int k = 0; k < 9; k++) push(32'h400 + 32'(k), 4'hF);
      chk("mid_count9", 64'(count), 64'd9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_count", 64'(count), 64'd0);
      chk("mid_empty", 64'(fifo_empty), 64'd1);
      chk("mid_ovf", 64'(overflow), 64'd0);
      chk("mid_udf", 64'(underflow), 64'd0);
      chk("mid_data", 64'(fifo_data), 64'h0);
      push(32'h0000_0500, 4'b0101);
      pop();
      chk("mid_new_data", 64'(fifo_data), 64'h A_0000_0500);
      chk("mid_new_empty", 64'(fifo_empty), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_write_fifo.md
# sdram_write_fifo

Synchronous 36-bit FIFO between the wishbone SDRAM slave front end and the SDRAM write sequencer. It accepts 32-bit host words with active-high byte enables, converts them to SDRAM DQM format, and buffers them. It presents them on the read side as `fifo_data`/`fifo_read`/`fifo_empty`, which plugs directly into the write sequencer's FIFO ports. Full, almost-full, level and sticky error flags let the front end throttle wishbone ACKs.

## Interface
- `ADDR_WIDTH`, 4, log2 of depth (depth = 2^ADDR_WIDTH entries).
- `AF_MARGIN`, 2, `almost_full` asserts when free entries ≤ AF_MARGIN.
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `wr_en`  input  1  push request; sampled on rising `clk`.
- `wr_data`  input  32  host word; [31:16] is the upper SDRAM half-word, [15:0] the lower.
- `wr_byte_en`  input  4  active-high byte enables; bit i covers `wr_data[8i+7:8i]`.
- `full`  output  1  no free entries.
- `almost_full`  output  1  free entries ≤ AF_MARGIN.
- `count`  output  ADDR_WIDTH+1  current occupancy.
- `overflow`  output  1  sticky: push attempted while full.
- `underflow`  output  1  sticky: pop attempted while empty.
- `fifo_read`  input  1  pop request from the write sequencer.
- `fifo_data`  output  36  {dqm[3:0], data[31:0]}; dqm = ~wr_byte_en.
- `fifo_empty`  output  1  no stored entries.

## Operation
- Entry format: `{~wr_byte_en, wr_data}`. `fifo_data[35:34]` masks [31:16] and `fifo_data[33:32]` masks [15:0]. DQM=1 means the byte is not written.
- Storage: 2^ADDR_WIDTH × 36 array. Write and read pointers are ADDR_WIDTH bits wide and wrap naturally modulo depth. `count` is tracked in an ADDR_WIDTH+1 bit register.
- Push: when `wr_en & ~full`, write the entry at `wr_ptr`, then increment `wr_ptr`.
- Pop: when `fifo_read & ~fifo_empty`, register `mem[rd_ptr]` into `fifo_data`, then increment `rd_ptr`. `fifo_data` holds its value until the next accepted pop.
- Simultaneous push and pop, not full and not empty: both are accepted and `count` is unchanged.
- Simultaneous push and pop at full: the pop is accepted and the push is ignored, with `overflow` set. Flags are evaluated before the edge; there is no bypass.
- Simultaneous push and pop at empty: the pop is ignored (`underflow` set, `fifo_data` unchanged) and the push is accepted. There is no write-to-read bypass.
- Push while full: the entry is dropped, pointers and count are unchanged, and `overflow` is set.
- Pop while empty: ignored; `underflow` is set.
- `overflow` and `underflow` clear only on `rst`.
- Flags are combinational from `count`:
  - `fifo_empty` = (count==0)
  - `full` = (count==2^ADDR_WIDTH)
  - `almost_full` = (2^ADDR_WIDTH − count ≤ AF_MARGIN)
- Reset values: `fifo_data`=36'h0, `fifo_empty`=1, `full`=0, `almost_full`=0 (given AF_MARGIN < depth), `count`=0, `overflow`=0, `underflow`=0. Pointers are 0.
- Reset mid-operation: all entries are discarded by pointer/count clear and the array contents are not cleared. `rst` has priority over any simultaneous `wr_en` or `fifo_read`.

## Timing
- Write-to-visible latency: a push accepted at edge N deasserts `fifo_empty` after edge N (visible in cycle N+1). The earliest pop is sampled at edge N+1.
- Read latency: `fifo_read` sampled at edge N gives valid `fifo_data` from edge N until the next accepted pop. The consumer may sample it any cycle ≥ N+1, matching a sequencer that pops then waits T_RCD.
- `count`, `full` and `almost_full` update on the edge of the accepted operation.
- Throughput: one push and one pop per cycle sustained.
- `fifo_read` is a single-cycle pulse from the consumer. A held-high `fifo_read` pops once per cycle while not empty.

## Structure
- Shared package/include (`sdram_include.v`): entry width 36, `SDRAM_DQM_WIDTH` = 4 and the field offsets (DQM at [35:32], data at [31:0]).
- One natural sub-module: `sdram_fifo_ram`, a simple dual-port 36-bit RAM with synchronous write and registered read. It infers block RAM and is parameterised by ADDR_WIDTH.
- Top level holds the pointers, count, flag logic, DQM inversion and the sticky error registers.

## Test plan
- Reset: assert `rst` 2 cycles with `wr_en`=1 -> `count`=0, `fifo_empty`=1, `fifo_data`=0, no entry stored.
- Single word: push `wr_data`=32'hDEADBEEF, `wr_byte_en`=4'b1101; pulse `fifo_read` -> next cycle `fifo_data`=36'h2_DEADBEEF, `fifo_empty`=1, `count`=0.
- Fill/wrap (ADDR_WIDTH=4): push 0..15 -> `full`=1 and `almost_full` from count 14. Push 16 -> dropped, `overflow`=1. Pop all -> 0..15 in order. Then repeat 20 push/pop pairs -> order preserved across pointer wrap.
- Simultaneous ops: at count 5, assert `wr_en` and `fifo_read` together for 10 cycles -> `count` stays 5 and data stays in order. At count 0, both asserted -> pop ignored, `underflow`=1, `count`=1.
- Hold behaviour: pop a word, wait 4 cycles without `fifo_read` -> `fifo_data` stable. Pop on empty -> `fifo_data` still unchanged.
- Mid-operation reset: at count 9, assert `rst` 1 cycle -> `count`=0, `fifo_empty`=1, flags cleared. A subsequent push/pop returns only the new word.
